// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and types for the round-robin arbiter driving the 4:1 data mux select.
package mux_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Mux select codes: requester i drives mux input a/b/c/d.
  localparam logic [SEL_W-1:0] SEL_A = 2'b00;
  localparam logic [SEL_W-1:0] SEL_B = 2'b01;
  localparam logic [SEL_W-1:0] SEL_C = 2'b10;
  localparam logic [SEL_W-1:0] SEL_D = 2'b11;

  // One-hot grant vector for a requester index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request bit at or after 'start', wrapping.
module rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   start,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] pos;

  // Walk the four positions from 'start'; the first requester seen wins.
  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves a latch.
    found = 1'b0;
    idx   = start;
    pos   = start;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = start + SEL_W'(k);
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the 4:1 data mux select and paces bounded bursts.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ready,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid,
  output logic               last
);

  state_t             state, state_nx;
  logic [SEL_W-1:0]   sel_nx;
  logic [NUM_REQ-1:0] grant_nx;
  logic [SEL_W-1:0]   ptr, ptr_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;

  logic               found;
  logic [SEL_W-1:0]   win;
  logic [SEL_W-1:0]   start;
  logic               at_end;
  logic               grant_end;

  // In IDLE the search follows the last grant; at grant end it follows the current select.
  assign start  = (state == ST_IDLE) ? ptr + 2'd1 : sel + 2'd1;
  assign valid  = (state == ST_ACTIVE) && req[sel];
  assign at_end = (cnt == CNT_W'(BURST - 1));
  assign last   = valid && at_end;
  // A grant ends when its owner drops out or the final beat is accepted.
  assign grant_end = (state == ST_ACTIVE) && (!req[sel] || (ready && at_end));

  rr_pick u_pick (
    .req   (req),
    .start (start),
    .found (found),
    .idx   (win)
  );

  // Next-state and next-grant decisions; everything holds unless a rule fires.
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    grant_nx = grant;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_nx = ST_ACTIVE;
          sel_nx   = win;
          grant_nx = onehot(win);
          ptr_nx   = win;
          cnt_nx   = '0;
        end
      end
      ST_ACTIVE: begin
        if (grant_end) begin
          cnt_nx = '0;
          if (found) begin
            sel_nx   = win;
            grant_nx = onehot(win);
            ptr_nx   = win;
          end else begin
            state_nx = ST_IDLE;
            grant_nx = '0;
          end
        end else if (valid && ready) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register; reset starts the first search at requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel   <= SEL_A;
      grant <= '0;
      ptr   <= SEL_D;
      cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nx;
      sel   <= sel_nx;
      grant <= grant_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that drives the 2-bit select of the team's 4:1, 4-bit data mux. Four requesters present 4-bit data directly on mux inputs a/b/c/d and raise a request. This block grants one requester at a time, drives the mux select, and signals valid for each beat until the downstream consumer accepts a bounded burst. It sits directly upstream of the mux select input and replaces any static tie-off of that select.

## Interface
- BURST, default 4: maximum accepted beats per grant; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  per-requester request; bit i corresponds to mux input a/b/c/d for i = 0/1/2/3.
- ready  input  1  downstream accepts the current beat.
- sel  output  2  mux select, registered; 00=a, 01=b, 10=c, 11=d.
- grant  output  4  one-hot grant, registered; all zero when idle.
- valid  output  1  current mux output is a valid beat; equals active & req[sel].
- last  output  1  current beat is the final beat of the burst; equals valid & (cnt == BURST-1).

## Operation
- Two states: IDLE and ACTIVE.
- Internal registers:
  - ptr (2 bits): index of the last granted requester.
  - cnt: beat counter, 4 bits wide.
- Arbitration: search req starting at ptr+1 (mod 4), wrapping to ptr. The first set bit wins. A lone requester may be granted again back-to-back.
- IDLE:
  - If req != 0, arbitrate. Next cycle: state=ACTIVE, sel=winner, grant=onehot(winner), ptr=winner, cnt=0.
  - If req == 0, stay in IDLE with grant=0 and sel held.
- ACTIVE, beat accepted (valid & ready):
  - If cnt != BURST-1, increment cnt.
  - If cnt == BURST-1, the grant ends.
- ACTIVE, req[sel]==0:
  - valid=0 in that same cycle.
  - The grant ends; a partial burst is allowed.
- ACTIVE, valid & ~ready: hold everything. sel and grant must not change while a beat is pending.
- Grant end:
  - Re-arbitrate in the same cycle, with req masked by nothing and the search starting at sel+1.
  - If there is a winner, the next cycle is ACTIVE with the new grant, cnt=0, and no idle bubble.
  - Otherwise go to IDLE with grant=0.
- Requests by non-granted requesters never affect the current grant.
- Reset values:
  - state=IDLE, sel=00, grant=0000, ptr=11 (first search starts at requester 0), cnt=0.
  - valid=0 and last=0.
- Reset mid-burst: asynchronous clear to the reset values. The burst is abandoned with no completion beat.

## Timing
- req rising in IDLE leads to grant/sel updated on the next clk edge, with valid high in that cycle if req is still high. Request-to-valid latency is 1 cycle.
- A beat transfers on a clk edge where valid & ready are both high.
- Grant-to-grant handoff: the cycle after the final accepted beat already shows the new sel/grant. Throughput is one beat per cycle under continuous ready.
- valid and last are combinational from registered state and req. The mux output is combinational from sel. Data plus valid therefore appear in the same cycle.
- Reset deassertion must be synchronised externally. The first arbitration happens on the first edge after rst_n is high.

## Structure
- Shared package/include file:
  - NUM_REQ=4 and SEL_W=2.
  - State encodings ST_IDLE/ST_ACTIVE.
  - Select codes SEL_A..SEL_D.
- One natural sub-module: rr_pick. It is combinational: inputs req[3:0] and start[1:0], outputs found and idx[1:0]. It is reused for both IDLE arbitration and grant-end re-arbitration.
- The top level contains the state register, ptr, cnt, and output logic, and instantiates the mux alongside it in the parent.

## Test plan
- Reset / single requester:
  - Stimulus: reset, then req=0001 with ready=1 held, BURST=4.
  - Response: 1 cycle later sel=00, grant=0001, and 4 valid beats with last on the 4th. sel=00 is then re-granted immediately with no gap.
- Round robin:
  - Stimulus: req=1111, ready=1.
  - Response: grants in order 0,1,2,3,0 with 4 beats each and zero idle cycles between grants.
- Backpressure:
  - Stimulus: req=0100, with ready low for 3 cycles mid-burst.
  - Response: sel=10 stable, valid high, cnt frozen. The burst still completes with exactly 4 accepted beats.
- Early drop:
  - Stimulus: req=0011, then requester 0 drops req after 2 accepted beats.
  - Response: valid=0 in the drop cycle, and the next cycle has grant=0010, sel=01, cnt=0.
- Wrap-around:
  - Stimulus: ptr=11 after granting requester d, then req=1001.
  - Response: requester a is granted next (sel=00), not d.
- Mid-burst reset:
  - Stimulus: assert rst_n=0 during a sel=11 grant.
  - Response: sel=00, grant=0000, valid=0 immediately without a clock edge. After release with req=1000, the first grant goes to sel=11.
